// File: rtl/pixel_sched_pkg.sv
// Shared types for the pixel write scheduler: source ids, pixel request and linear address helper.
package pixel_sched_pkg;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_CLEAR,
    SRC_RASTER,
    SRC_SIMD
  } src_e;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] color;
  } pixel_req_t;

  // Full-width product; callers truncate to their address width.
  function automatic logic [63:0] lin_addr(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic [31:0] width);
    return ({32'd0, y} * {32'd0, width}) + {32'd0, x};
  endfunction

endpackage

// File: rtl/pixel_sched_grant.sv
// Grant arbiter: clear has priority with a starvation guard, raster/SIMD share round-robin.
// Combinational grant, no latency; grants nothing while accept_ok is low.
module pixel_sched_grant
  import pixel_sched_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_valid,
  input  logic raster_valid,
  input  logic simd_valid,
  input  logic accept_ok,
  output src_e grant
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  src_e             rr_ptr;
  logic [CNT_W-1:0] starve_cnt;
  logic             rs_any;
  logic             starved;

  assign rs_any  = raster_valid | simd_valid;
  assign starved = (starve_cnt == LIMIT_C) & rs_any;

  always_comb begin
    grant = SRC_NONE;
    if (accept_ok) begin
      if (clear_valid && !starved) begin
        grant = SRC_CLEAR;
      end else if (rs_any) begin
        if (rr_ptr == SRC_RASTER) grant = raster_valid ? SRC_RASTER : SRC_SIMD;
        else                      grant = simd_valid   ? SRC_SIMD   : SRC_RASTER;
      end
    end
  end

  // Every non-NONE grant is a completed transfer, since grants go only to valid sources.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= SRC_RASTER;
      starve_cnt <= '0;
    end else begin
      case (grant)
        SRC_CLEAR: begin
          if (!rs_any)                   starve_cnt <= '0;
          else if (starve_cnt != LIMIT_C) starve_cnt <= starve_cnt + 1'b1;
        end
        SRC_RASTER: begin
          rr_ptr     <= SRC_SIMD;
          starve_cnt <= '0;
        end
        SRC_SIMD: begin
          rr_ptr     <= SRC_RASTER;
          starve_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_scheduler.sv
// Shares one framebuffer write port among clear/raster/SIMD; 1-cycle handshake-to-wr_valid, no skid buffer,
// readies drop while a held write is not accepted. Optional counters under PIXEL_SCHED_STATS_EN.
module pixel_write_scheduler
  import pixel_sched_pkg::*;
#(
  parameter int unsigned FB_WIDTH     = 640,
  parameter int unsigned FB_HEIGHT    = 480,
  parameter int          ADDR_W       = 19,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_valid,
  output logic              clear_ready,
  input  logic [31:0]       clear_x,
  input  logic [31:0]       clear_y,
  input  logic [31:0]       clear_color,
  input  logic              raster_valid,
  output logic              raster_ready,
  input  logic [31:0]       raster_x,
  input  logic [31:0]       raster_y,
  input  logic [31:0]       raster_color,
  input  logic              simd_valid,
  output logic              simd_ready,
  input  logic [31:0]       simd_x,
  input  logic [31:0]       simd_y,
  input  logic [31:0]       simd_color,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              oob_drop,
  output logic              busy
`ifdef PIXEL_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_clear,
  output logic [31:0]       stat_raster,
  output logic [31:0]       stat_simd,
  output logic [31:0]       stat_oob
`endif
);

  src_e       grant;
  pixel_req_t sel;
  logic       accept_ok;
  logic       take;
  logic       in_bounds;

  // Gating with rst_n keeps every ready low while reset is held.
  assign accept_ok = rst_n & (~wr_valid | wr_ready);

  pixel_sched_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_valid  (clear_valid),
    .raster_valid (raster_valid),
    .simd_valid   (simd_valid),
    .accept_ok    (accept_ok),
    .grant        (grant)
  );

  always_comb begin
    sel = '0;
    case (grant)
      SRC_CLEAR:  sel = '{x: clear_x,  y: clear_y,  color: clear_color};
      SRC_RASTER: sel = '{x: raster_x, y: raster_y, color: raster_color};
      SRC_SIMD:   sel = '{x: simd_x,   y: simd_y,   color: simd_color};
      default:    sel = '0;
    endcase
  end

  assign clear_ready  = (grant == SRC_CLEAR);
  assign raster_ready = (grant == SRC_RASTER);
  assign simd_ready   = (grant == SRC_SIMD);
  assign take         = (grant != SRC_NONE);
  assign in_bounds    = (sel.x < FB_WIDTH) && (sel.y < FB_HEIGHT);
  assign busy         = wr_valid | clear_valid | raster_valid | simd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      oob_drop <= 1'b0;
    end else begin
      oob_drop <= take & ~in_bounds;
      if (take && in_bounds) begin
        wr_valid <= 1'b1;
        wr_addr  <= ADDR_W'(lin_addr(sel.x, sel.y, FB_WIDTH));
        wr_data  <= sel.color;
      end else if (wr_ready) begin
        wr_valid <= 1'b0;
      end
    end
  end

`ifdef PIXEL_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_clear  <= '0;
      stat_raster <= '0;
      stat_simd   <= '0;
      stat_oob    <= '0;
    end else begin
      if (grant == SRC_CLEAR)  stat_clear  <= stat_clear + 32'd1;
      if (grant == SRC_RASTER) stat_raster <= stat_raster + 32'd1;
      if (grant == SRC_SIMD)   stat_simd   <= stat_simd + 32'd1;
      if (take && !in_bounds)  stat_oob    <= stat_oob + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_write_scheduler.sv
// Randomized scoreboard bench for pixel_write_scheduler against a rule-level reference model.
module tb_pixel_write_scheduler;

  localparam int W     = 640;
  localparam int H     = 480;
  localparam int LIMIT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_valid, clear_ready, raster_valid, raster_ready, simd_valid, simd_ready;
  logic [31:0] clear_x, clear_y, clear_color;
  logic [31:0] raster_x, raster_y, raster_color;
  logic [31:0] simd_x, simd_y, simd_color;
  logic        wr_valid, wr_ready;
  logic [18:0] wr_addr;
  logic [31:0] wr_data;
  logic        oob_drop, busy;
`ifdef PIXEL_SCHED_STATS_EN
  logic [31:0] stat_clear, stat_raster, stat_simd, stat_oob;
`endif

  always #5 clk = ~clk;

  pixel_write_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_valid  (clear_valid),
    .clear_ready  (clear_ready),
    .clear_x      (clear_x),
    .clear_y      (clear_y),
    .clear_color  (clear_color),
    .raster_valid (raster_valid),
    .raster_ready (raster_ready),
    .raster_x     (raster_x),
    .raster_y     (raster_y),
    .raster_color (raster_color),
    .simd_valid   (simd_valid),
    .simd_ready   (simd_ready),
    .simd_x       (simd_x),
    .simd_y       (simd_y),
    .simd_color   (simd_color),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .oob_drop     (oob_drop),
    .busy         (busy)
`ifdef PIXEL_SCHED_STATS_EN
    ,
    .stat_clear   (stat_clear),
    .stat_raster  (stat_raster),
    .stat_simd    (stat_simd),
    .stat_oob     (stat_oob)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pending pixel per source (0=clear,1=raster,2=simd), expected writes, expected drop pulses.
  typedef struct {
    logic [18:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         expq[$];
  bit          exp_oob[0:8191];
  int          cyc = 0;
  bit          svld[3];
  logic [31:0] sx[3], sy[3], sc[3];
  int          streak;
  bit          turn_simd;
  bit          held;
  int          cnt_src[3];
  int          cnt_oob;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive();
    clear_valid  = svld[0]; clear_x  = sx[0]; clear_y  = sy[0]; clear_color  = sc[0];
    raster_valid = svld[1]; raster_x = sx[1]; raster_y = sy[1]; raster_color = sc[1];
    simd_valid   = svld[2]; simd_x   = sx[2]; simd_y   = sy[2]; simd_color   = sc[2];
  endtask

  task automatic gen(input int s, input int po);
    svld[s] = 1'b1;
    sc[s]   = $urandom;
    if ($urandom_range(99) < po) begin
      case ($urandom_range(3))
        0:       begin sx[s] = 32'd640;         sy[s] = $urandom_range(479); end
        1:       begin sx[s] = $urandom_range(639); sy[s] = 32'd480; end
        2:       begin sx[s] = 32'hFFFF_FFFF;   sy[s] = 32'd0; end
        default: begin sx[s] = $urandom_range(639); sy[s] = 32'd480 + $urandom_range(100000); end
      endcase
    end else begin
      sx[s] = ($urandom_range(7) == 0) ? 32'd639 : 32'($urandom_range(639));
      sy[s] = ($urandom_range(7) == 0) ? 32'd479 : 32'($urandom_range(479));
    end
  endtask

  // One clock: starts and ends at posedge+1. Percent chances for new source pixels, wr_ready and OOB coords.
  task automatic step(input int pc, input int pr, input int ps, input int pw, input int po);
    int       p[3];
    int       g;
    bit       acc;
    logic [2:0] exp_rdy;
    p = '{pc, pr, ps};
    for (int s = 0; s < 3; s++)
      if (!svld[s] && $urandom_range(99) < p[s]) gen(s, po);
    wr_ready = ($urandom_range(99) < pw);
    drive();
    @(negedge clk);
    check("busy", busy, held | svld[0] | svld[1] | svld[2]);
    acc = !held || wr_ready;
    g   = -1;
    if (acc) begin
      if (svld[0] && !(streak == LIMIT && (svld[1] || svld[2]))) g = 0;
      else if (svld[1] && svld[2]) g = turn_simd ? 2 : 1;
      else if (svld[1])            g = 1;
      else if (svld[2])            g = 2;
    end
    exp_rdy = (g < 0) ? 3'b000 : (3'b100 >> g);
    check("readies", {clear_ready, raster_ready, simd_ready}, exp_rdy);
    if (held && wr_ready) held = 0;
    if (g >= 0) begin
      if (sx[g] < W && sy[g] < H) begin
        expq.push_back('{a: 19'(sy[g] * 32'(W) + sx[g]), d: sc[g]});
        held = 1;
      end else begin
        exp_oob[cyc + 1] = 1'b1;
        cnt_oob++;
      end
      cnt_src[g]++;
      if (g == 0) streak = (svld[1] || svld[2]) ? ((streak < LIMIT) ? streak + 1 : streak) : 0;
      else begin
        streak    = 0;
        turn_simd = (g == 1);
      end
      svld[g] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      check("oob_drop", oob_drop, exp_oob[cyc]);
      if (wr_valid) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wr_unexpected: got write addr=%0d, expected no write", wr_addr);
        end else begin
          check("wr_addr", wr_addr, expq[0].a);
          check("wr_data", wr_data, expq[0].d);
          if (wr_ready) void'(expq.pop_front());
        end
      end
    end
  end

  task automatic model_reset();
    streak    = 0;
    turn_simd = 0;
    held      = 0;
    cnt_oob   = 0;
    for (int s = 0; s < 3; s++) begin
      svld[s]    = 1'b0;
      cnt_src[s] = 0;
    end
    expq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ox[3];
    logic [31:0] oy[3];
    ox = '{32'd640, 32'd0, 32'hFFFF_FFFF};
    oy = '{32'd0, 32'd480, 32'd0};

    // Reset state with all sources requesting.
    model_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      svld[s] = 1'b1; sx[s] = 32'(s); sy[s] = 32'd1; sc[s] = 32'hA0 + 32'(s);
    end
    wr_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #2;
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_oob_drop", oob_drop, 0);
    check("rst_readies", {clear_ready, raster_ready, simd_ready}, 0);
    model_reset();
    drive();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single raster pixel (3,2) lands at 2*640+3.
    svld[1] = 1'b1; sx[1] = 32'd3; sy[1] = 32'd2; sc[1] = 32'hFF00FF00;
    step(0, 0, 0, 100, 0);
    check("t1_wr_valid", wr_valid, 1);
    check("t1_wr_addr", wr_addr, 19'd1283);
    check("t1_wr_data", wr_data, 32'hFF00FF00);
    step(0, 0, 0, 100, 0);

    // Out-of-bounds SIMD pixels: handshake completes, no write, one-cycle drop pulse.
    for (int k = 0; k < 3; k++) begin
      svld[2] = 1'b1; sx[2] = ox[k]; sy[2] = oy[k]; sc[2] = 32'h1234_0000 + 32'(k);
      step(0, 0, 0, 100, 0);
      check("t4_oob_pulse", oob_drop, 1);
      check("t4_no_write", wr_valid, 0);
      step(0, 0, 0, 100, 0);
      check("t4_oob_clear", oob_drop, 0);
    end

    // Raster/SIMD alternation, then all three continuously valid for starvation guard.
    repeat (20) step(0, 100, 100, 100, 0);
    repeat (80) step(100, 100, 100, 100, 0);

    // Held write under 5 stalled cycles, then release with sources waiting.
    svld[0] = 1'b1; sx[0] = 32'd10; sy[0] = 32'd20; sc[0] = 32'hCAFE0001;
    step(0, 0, 0, 100, 0);
    repeat (5) step(100, 100, 100, 0, 0);
    repeat (3) step(100, 100, 100, 100, 0);

    // Randomized traffic across several load / backpressure / OOB mixes.
    repeat (400) step(30, 30, 30, 70, 10);
    repeat (400) step(90, 60, 60, 50, 20);
    repeat (400) step(80, 80, 80, 90, 5);
    repeat (300) step(20, 90, 90, 30, 30);
    repeat (20) step(0, 0, 0, 100, 0);
    check("drain_empty", expq.size(), 0);
`ifdef PIXEL_SCHED_STATS_EN
    check("stat_clear", stat_clear, cnt_src[0]);
    check("stat_raster", stat_raster, cnt_src[1]);
    check("stat_simd", stat_simd, cnt_src[2]);
    check("stat_oob", stat_oob, cnt_oob);
`endif

    // Async reset while a write is held; round-robin must restart at raster.
    svld[1] = 1'b1; sx[1] = 32'd5; sy[1] = 32'd5; sc[1] = 32'h0000BEEF;
    step(0, 0, 0, 100, 0);
    wr_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_wr_valid", wr_valid, 0);
    check("t6_readies_in_rst", {clear_ready, raster_ready, simd_ready}, 0);
    model_reset();
    for (int k = 0; k < 8192; k++) exp_oob[k] = 1'b0;
    drive();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (10) step(0, 100, 100, 100, 0);
    repeat (10) step(0, 0, 0, 100, 0);
    check("final_drain_empty", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
